// File: rtl/store_inst_encode.sv
// rtl/store_inst_encode.sv - builds chunked 128-bit VTA store instructions from store commands
// Optional STORE_INST_ENCODE_PERF_EN adds instruction and stall counters.
module store_inst_encode #(
    parameter int MAX_YSIZE = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         io_cmd_valid,
    output logic         io_cmd_ready,
    input  logic [15:0]  io_cmd_sram_offset,
    input  logic [31:0]  io_cmd_dram_offset,
    input  logic [15:0]  io_cmd_ysize,
    input  logic [15:0]  io_cmd_xsize,
    input  logic [15:0]  io_cmd_xstride,
    input  logic         io_cmd_pop_prev,
    input  logic         io_cmd_push_prev,
    output logic         io_inst_valid,
    input  logic         io_inst_ready,
    output logic [127:0] io_inst,
    output logic         io_busy
`ifdef STORE_INST_ENCODE_PERF_EN
    ,
    output logic [31:0]  io_inst_count,
    output logic [31:0]  io_stall_cycles
`endif
);

    localparam logic [15:0] MAX_ROWS = 16'(MAX_YSIZE);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t state, next_state;

    // Cursor for the chunk after the one currently on io_inst
    logic [15:0] sram_q;
    logic [31:0] dram_q;
    logic [15:0] rem_q;
    logic [15:0] xsize_q;
    logic [15:0] xstride_q;
    logic        pop_q;
    logic        push_q;

    logic        use_cmd;
    logic [15:0] cur_rem;
    logic [15:0] cur_sram;
    logic [31:0] cur_dram;
    logic [15:0] cur_xsize;
    logic [15:0] cur_xstride;
    logic        cur_pop;
    logic        cur_push;
    logic        sync;
    logic        last_chunk;
    logic [15:0] rows;
    logic        pop_bit;
    logic        push_bit;
    logic [31:0] sram_step;
    logic [31:0] dram_step;
    logic [15:0] sram_next;
    logic [31:0] dram_next;
    logic [15:0] rem_next;
    logic [127:0] chunk;
    logic        load;

    assign io_cmd_ready = (state == IDLE);
    assign io_busy      = (state != IDLE);

    // Chunk builder: in IDLE it works from the raw command, in EMIT from the cursor
    always_comb begin
        use_cmd     = (state == IDLE);
        cur_rem     = use_cmd ? io_cmd_ysize       : rem_q;
        cur_sram    = use_cmd ? io_cmd_sram_offset : sram_q;
        cur_dram    = use_cmd ? io_cmd_dram_offset : dram_q;
        cur_xsize   = use_cmd ? io_cmd_xsize       : xsize_q;
        cur_xstride = use_cmd ? io_cmd_xstride     : xstride_q;
        cur_pop     = use_cmd ? io_cmd_pop_prev    : pop_q;
        cur_push    = use_cmd ? io_cmd_push_prev   : push_q;

        sync       = use_cmd && ((io_cmd_xsize == 16'd0) || (io_cmd_ysize == 16'd0));
        rows       = sync ? 16'd0 : ((cur_rem > MAX_ROWS) ? MAX_ROWS : cur_rem);
        last_chunk = sync || (cur_rem <= MAX_ROWS);
        pop_bit    = use_cmd && cur_pop;
        push_bit   = last_chunk && cur_push;

        sram_step = {16'd0, rows} * {16'd0, cur_xsize};
        dram_step = {16'd0, rows} * {16'd0, cur_xstride};
        sram_next = cur_sram + sram_step[15:0];
        dram_next = cur_dram + dram_step;
        rem_next  = sync ? 16'd0 : (cur_rem - rows);

        chunk = {16'h0000, cur_xstride, (sync ? 16'h0000 : cur_xsize), rows,
                 7'h00, cur_dram, cur_sram, 2'b00,
                 1'b0, push_bit, 1'b0, pop_bit, 3'b001};
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (io_cmd_valid) begin
                    next_state = EMIT;
                    load       = 1'b1;
                end
            end
            EMIT: begin
                if (io_inst_ready) begin
                    if (rem_q == 16'd0) begin
                        next_state = IDLE;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_inst       <= '0;
            io_inst_valid <= 1'b0;
            sram_q        <= '0;
            dram_q        <= '0;
            rem_q         <= '0;
            xsize_q       <= '0;
            xstride_q     <= '0;
            pop_q         <= 1'b0;
            push_q        <= 1'b0;
        end else if (load) begin
            io_inst       <= chunk;
            io_inst_valid <= 1'b1;
            sram_q        <= sram_next;
            dram_q        <= dram_next;
            rem_q         <= rem_next;
            if (use_cmd) begin
                xsize_q   <= io_cmd_xsize;
                xstride_q <= io_cmd_xstride;
                pop_q     <= io_cmd_pop_prev;
                push_q    <= io_cmd_push_prev;
            end
        end else if ((state == EMIT) && io_inst_ready) begin
            io_inst_valid <= 1'b0;
        end
    end

`ifdef STORE_INST_ENCODE_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_inst_count   <= '0;
            io_stall_cycles <= '0;
        end else begin
            if (io_inst_valid && io_inst_ready) begin
                io_inst_count <= io_inst_count + 32'd1;
            end
            if (io_inst_valid && !io_inst_ready) begin
                io_stall_cycles <= io_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_store_inst_encode.sv
// tb/tb_store_inst_encode.sv - scoreboard bench for store_inst_encode
module tb_store_inst_encode;

    logic         clock;
    logic         reset;
    logic         io_cmd_valid;
    logic         io_cmd_ready;
    logic [15:0]  io_cmd_sram_offset;
    logic [31:0]  io_cmd_dram_offset;
    logic [15:0]  io_cmd_ysize;
    logic [15:0]  io_cmd_xsize;
    logic [15:0]  io_cmd_xstride;
    logic         io_cmd_pop_prev;
    logic         io_cmd_push_prev;
    logic         io_inst_valid;
    logic         io_inst_ready;
    logic [127:0] io_inst;
    logic         io_busy;
`ifdef STORE_INST_ENCODE_PERF_EN
    logic [31:0]  io_inst_count;
    logic [31:0]  io_stall_cycles;
`endif

    store_inst_encode #(.MAX_YSIZE(64)) dut (
        .clock              (clock),
        .reset              (reset),
        .io_cmd_valid       (io_cmd_valid),
        .io_cmd_ready       (io_cmd_ready),
        .io_cmd_sram_offset (io_cmd_sram_offset),
        .io_cmd_dram_offset (io_cmd_dram_offset),
        .io_cmd_ysize       (io_cmd_ysize),
        .io_cmd_xsize       (io_cmd_xsize),
        .io_cmd_xstride     (io_cmd_xstride),
        .io_cmd_pop_prev    (io_cmd_pop_prev),
        .io_cmd_push_prev   (io_cmd_push_prev),
        .io_inst_valid      (io_inst_valid),
        .io_inst_ready      (io_inst_ready),
        .io_inst            (io_inst),
        .io_busy            (io_busy)
`ifdef STORE_INST_ENCODE_PERF_EN
        ,
        .io_inst_count      (io_inst_count),
        .io_stall_cycles    (io_stall_cycles)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    logic [127:0] exp_q[$];
    int hs_cycles[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    function automatic logic [127:0] mk(input logic [15:0] sram, input logic [31:0] dram,
                                        input logic [15:0] ys, input logic [15:0] xs,
                                        input logic [15:0] xst, input logic pop, input logic push);
        return {16'h0, xst, xs, ys, 7'h0, dram, sram, 2'b00, 1'b0, push, 1'b0, pop, 3'b001};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every instruction handshake pops one expected instruction
    always @(negedge clock) begin
        if (reset && io_inst_valid && io_inst_ready) begin
            hs_cycles.push_back(cycle);
            if (exp_q.size() == 0) begin
                chk("unexpected_inst", io_inst, 128'h0);
                if (io_inst == 128'h0) begin
                    miscompares++;
                    $display("FAIL unexpected_inst: got extra instruction expected none");
                end
            end else begin
                chk("inst", io_inst, exp_q.pop_front());
            end
        end
    end

    task automatic send_cmd(input logic [15:0] sram, input logic [31:0] dram, input logic [15:0] ys,
                            input logic [15:0] xs, input logic [15:0] xst,
                            input logic pop, input logic push);
        @(posedge clock);
        #1;
        io_cmd_sram_offset = sram;
        io_cmd_dram_offset = dram;
        io_cmd_ysize       = ys;
        io_cmd_xsize       = xs;
        io_cmd_xstride     = xst;
        io_cmd_pop_prev    = pop;
        io_cmd_push_prev   = push;
        io_cmd_valid       = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (io_cmd_ready) break;
        end
        @(posedge clock);
        #1;
        io_cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || io_busy) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk({name, "_drain_timeout"}, 128'(n >= 3000), 128'd0);
        chk({name, "_cmd_ready_after"}, 128'(io_cmd_ready), 128'd1);
        chk({name, "_busy_after"}, 128'(io_busy), 128'd0);
    endtask

    logic [127:0] ref_inst;

    initial begin
        reset = 1'b0;
        io_cmd_valid = 1'b0;
        io_cmd_sram_offset = '0;
        io_cmd_dram_offset = '0;
        io_cmd_ysize = '0;
        io_cmd_xsize = '0;
        io_cmd_xstride = '0;
        io_cmd_pop_prev = 1'b0;
        io_cmd_push_prev = 1'b0;
        io_inst_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", 128'(io_inst_valid), 128'd0);
        chk("rst_inst", io_inst, 128'd0);
        chk("rst_busy", 128'(io_busy), 128'd0);
        chk("rst_cmd_ready", 128'(io_cmd_ready), 128'd1);
        reset = 1'b1;

        // Single chunk
        exp_q.push_back(mk(16'h0010, 32'h1000, 16'd8, 16'd4, 16'd16, 1'b1, 1'b1));
        send_cmd(16'h0010, 32'h1000, 16'd8, 16'd4, 16'd16, 1'b1, 1'b1);
        wait_drain("single");

        // Split 150 rows, ready held: three back-to-back chunks
        hs_cycles.delete();
        exp_q.push_back(mk(16'd0,   32'd0,    16'd64, 16'd2, 16'd8, 1'b1, 1'b0));
        exp_q.push_back(mk(16'd128, 32'd512,  16'd64, 16'd2, 16'd8, 1'b0, 1'b0));
        exp_q.push_back(mk(16'd256, 32'd1024, 16'd22, 16'd2, 16'd8, 1'b0, 1'b1));
        send_cmd(16'd0, 32'd0, 16'd150, 16'd2, 16'd8, 1'b1, 1'b1);
        wait_drain("split");
        chk("split_hs_count", 128'(hs_cycles.size()), 128'd3);
        if (hs_cycles.size() == 3)
            chk("split_consecutive", 128'(hs_cycles[2] - hs_cycles[0]), 128'd2);

        // Sync: xsize=0
        exp_q.push_back(mk(16'h0022, 32'h44, 16'd0, 16'd0, 16'd7, 1'b0, 1'b1));
        send_cmd(16'h0022, 32'h44, 16'd5, 16'd0, 16'd7, 1'b0, 1'b1);
        wait_drain("sync_x0");

        // Sync: ysize=0
        exp_q.push_back(mk(16'h0001, 32'h2, 16'd0, 16'd0, 16'd3, 1'b1, 1'b0));
        send_cmd(16'h0001, 32'h2, 16'd0, 16'd9, 16'd3, 1'b1, 1'b0);
        wait_drain("sync_y0");

        // Boundary: exactly MAX rows, then MAX+1
        exp_q.push_back(mk(16'd5, 32'd6, 16'd64, 16'd3, 16'd4, 1'b1, 1'b1));
        send_cmd(16'd5, 32'd6, 16'd64, 16'd3, 16'd4, 1'b1, 1'b1);
        wait_drain("max_rows");
        exp_q.push_back(mk(16'd0,   32'd0,   16'd64, 16'd3, 16'd4, 1'b1, 1'b0));
        exp_q.push_back(mk(16'd192, 32'd256, 16'd1,  16'd3, 16'd4, 1'b0, 1'b1));
        send_cmd(16'd0, 32'd0, 16'd65, 16'd3, 16'd4, 1'b1, 1'b1);
        wait_drain("max_plus1");

        // Backpressure during split
        io_inst_ready = 1'b0;
        exp_q.push_back(mk(16'd0,   32'd0,    16'd64, 16'd2, 16'd8, 1'b1, 1'b0));
        exp_q.push_back(mk(16'd128, 32'd512,  16'd64, 16'd2, 16'd8, 1'b0, 1'b0));
        exp_q.push_back(mk(16'd256, 32'd1024, 16'd22, 16'd2, 16'd8, 1'b0, 1'b1));
        send_cmd(16'd0, 32'd0, 16'd150, 16'd2, 16'd8, 1'b1, 1'b1);
        @(negedge clock);
        ref_inst = io_inst;
        for (int i = 0; i < 5; i++) begin
            chk("bp1_valid", 128'(io_inst_valid), 128'd1);
            chk("bp1_stable", io_inst, ref_inst);
            chk("bp1_cmd_ready", 128'(io_cmd_ready), 128'd0);
            @(negedge clock);
        end
        @(posedge clock);
        #1 io_inst_ready = 1'b1;
        @(posedge clock);
        #1 io_inst_ready = 1'b0;
        @(negedge clock);
        ref_inst = io_inst;
        chk("bp2_sram", 128'(ref_inst[24:9]), 128'd128);
        for (int i = 0; i < 3; i++) begin
            chk("bp2_valid", 128'(io_inst_valid), 128'd1);
            chk("bp2_stable", io_inst, ref_inst);
            chk("bp2_cmd_ready", 128'(io_cmd_ready), 128'd0);
            @(negedge clock);
        end
        @(posedge clock);
        #1 io_inst_ready = 1'b1;
        wait_drain("backpressure");

        // Offset wrap
        exp_q.push_back(mk(16'hFFF0, 32'hFFFFFFF0, 16'd64, 16'd1, 16'd1, 1'b0, 1'b0));
        exp_q.push_back(mk(16'h0030, 32'h00000030, 16'd64, 16'd1, 16'd1, 1'b0, 1'b0));
        send_cmd(16'hFFF0, 32'hFFFFFFF0, 16'd128, 16'd1, 16'd1, 1'b0, 1'b0);
        wait_drain("wrap");

        // Reset during second chunk
        io_inst_ready = 1'b0;
        exp_q.push_back(mk(16'd0,   32'd0,    16'd64, 16'd2, 16'd8, 1'b1, 1'b0));
        exp_q.push_back(mk(16'd128, 32'd512,  16'd64, 16'd2, 16'd8, 1'b0, 1'b0));
        exp_q.push_back(mk(16'd256, 32'd1024, 16'd22, 16'd2, 16'd8, 1'b0, 1'b1));
        send_cmd(16'd0, 32'd0, 16'd150, 16'd2, 16'd8, 1'b1, 1'b1);
        @(posedge clock);
        #1 io_inst_ready = 1'b1;
        @(posedge clock);
        #1 io_inst_ready = 1'b0;
        @(negedge clock);
        chk("mid_busy_before", 128'(io_busy), 128'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(io_inst_valid), 128'd0);
        chk("mid_rst_busy", 128'(io_busy), 128'd0);
        chk("mid_rst_cmd_ready", 128'(io_cmd_ready), 128'd1);
        chk("mid_rst_inst", io_inst, 128'd0);
        chk("mid_rst_pending", 128'(exp_q.size()), 128'd2);
`ifdef STORE_INST_ENCODE_PERF_EN
        chk("mid_rst_count", 128'(io_inst_count), 128'd0);
        chk("mid_rst_stall", 128'(io_stall_cycles), 128'd0);
`endif
        exp_q.delete();
        @(posedge clock);
        #1 reset = 1'b1;
        io_inst_ready = 1'b1;
        exp_q.push_back(mk(16'h0100, 32'h2000, 16'd3, 16'd5, 16'd9, 1'b0, 1'b1));
        send_cmd(16'h0100, 32'h2000, 16'd3, 16'd5, 16'd9, 1'b0, 1'b1);
        wait_drain("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_inst_encode.md
Name: store_inst_encode

Overview:
- Counterpart of the store-queue instruction decoder: builds 128-bit VTA store instructions from a high-level store command.
- Splits a command of ysize rows into instructions of at most MAX_YSIZE rows each.
- Advances SRAM/DRAM offsets per chunk, places dependency flags on the first and last chunk, and emits a sync instruction (xsize=0) for empty commands.
- Sits between the command fetch/generator and the store instruction queue.

Parameters:
- MAX_YSIZE, 64, maximum rows per emitted instruction; range 1..65535.

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous active-low reset
- io_cmd_valid  in  1  command valid
- io_cmd_ready  out  1  command accepted when valid&ready
- io_cmd_sram_offset  in  16  SRAM base (units)
- io_cmd_dram_offset  in  32  DRAM base (units)
- io_cmd_ysize  in  16  total rows
- io_cmd_xsize  in  16  row length; 0 requests sync
- io_cmd_xstride  in  16  DRAM row stride
- io_cmd_pop_prev  in  1  wait on compute token before first instruction
- io_cmd_push_prev  in  1  release token to compute after last instruction
- io_inst_valid  out  1  instruction valid
- io_inst_ready  in  1  queue accepts instruction
- io_inst  out  128  encoded instruction
- io_busy  out  1  high while not IDLE

Behaviour:
- Encoding of io_inst:
  - [2:0] opcode = 3'b001.
  - [3] pop_prev, [4] pop_next = 0, [5] push_prev, [6] push_next = 0.
  - [8:7] id = 0.
  - [24:9] sram_offset, [56:25] dram_offset, [63:57] = 0.
  - [79:64] ysize, [95:80] xsize, [111:96] xstride, [127:112] pads = 0.
- States: IDLE, EMIT.
- Reset:
  - State IDLE.
  - io_inst_valid=0, io_inst=0, io_busy=0.
  - io_cmd_ready=1, combinationally equal to (state==IDLE).
- IDLE handshake: on io_cmd_valid&io_cmd_ready, latch all command fields, compute the first chunk, go to EMIT. io_inst_valid rises the next cycle (latency 1).
- Sync case: if xsize==0 or ysize==0, emit exactly one instruction with ysize=0, xsize=0, xstride=cmd xstride, offsets=cmd offsets, and both flags from the command.
- Normal case:
  - Chunk rows r = min(remaining, MAX_YSIZE).
  - pop_prev = cmd pop_prev only on the first chunk; push_prev = cmd push_prev only on the last chunk. A single-chunk command carries both.
  - After each accepted chunk:
    - sram += r*xsize, truncated to 16 bits (wraps).
    - dram += r*xstride, truncated to 32 bits (wraps).
    - remaining -= r.
- EMIT:
  - io_inst and io_inst_valid are registered and held stable while valid&!ready.
  - On io_inst_ready: if that was the last chunk, go to IDLE and deassert valid. Otherwise present the next chunk in the following cycle with valid still high, so back-to-back chunks go out one per cycle.
- No new command is accepted until the cycle after the last instruction handshake.
- ysize=65535 with MAX_YSIZE=64: 1024 chunks, the last of 63 rows. Chunk count = ceil(ysize/MAX_YSIZE).
- Reset asserted mid-command: command dropped, all outputs return to reset values immediately.

Optional Feature:
- Macro: STORE_INST_ENCODE_PERF_EN.
- Defined:
  - Adds output io_inst_count (32 bits), reset to 0.
  - Increments on every io_inst handshake, wraps at 2^32.
  - Adds output io_stall_cycles (32 bits), incremented each cycle io_inst_valid&!io_inst_ready.
- Undefined: these ports and their counters are absent. Otherwise identical behaviour.

Test Plan:
- Single chunk, ready held high. Cmd sram=0x0010, dram=0x1000, ysize=8, xsize=4, xstride=16, pop=1, push=1 -> one instruction on the next cycle with opcode=1, bit3=1, bit5=1, ysize=8, xsize=4, xstride=16, sram=0x0010, dram=0x1000. io_cmd_ready returns 1 the cycle after.
- Split, MAX_YSIZE=64. Cmd ysize=150, xsize=2, xstride=8, sram=0, dram=0, pop=1, push=1 -> three instructions:
  - ysize 64/64/22.
  - sram 0/128/256, dram 0/512/1024.
  - bit3 set only on the first, bit5 set only on the last.
  - Emitted on consecutive cycles when ready is held.
- Sync. Cmd xsize=0, ysize=5, pop=0, push=1 -> one instruction with opcode=1, xsize=0, ysize=0, bit5=1, bit3=0.
- Backpressure. io_inst_ready low for 5 cycles during the split case -> io_inst stable and valid high throughout. No chunk lost or duplicated. io_cmd_ready stays 0.
- Wrap. sram=0xFFF0, dram=0xFFFFFFF0, ysize=128, xsize=1, xstride=1 -> second chunk sram=0x0030, dram=0x00000030.
- Reset mid-command: reset low during the second chunk of the split case -> valid=0, busy=0, cmd_ready=1. A new command after release encodes from a clean state. PERF counters (when defined) return to 0.
